// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the shared-ALU controller.
// Holds the alufn encodings, the controller FSM state type and the default
// multiply latency.
package alu_pkg;

  localparam int MUL_CYCLES_DEF = 3;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_MUL = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b000100;
  localparam logic [5:0] FN_OR  = 6'b000101;
  localparam logic [5:0] FN_XOR = 6'b000110;
  localparam logic [5:0] FN_SLL = 6'b001000;
  localparam logic [5:0] FN_SRL = 6'b001001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ALU.sv
// ALU: combinational arithmetic/logic unit driven by the controller's operand
// registers. Overflow is signed overflow for ADD/SUB and 0 otherwise; zero
// flags an all-zero result. Unknown codes produce a zero result.
module ALU
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       alufn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] otp,
  output logic             overflow,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  // Decode alufn and compute the result and flags
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    otp      = '0;
    overflow = 1'b0;
    case (alufn)
      FN_ADD: begin
        otp      = a + b;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (otp[WIDTH-1] != a[WIDTH-1]);
      end
      FN_SUB: begin
        otp      = a - b;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (otp[WIDTH-1] != a[WIDTH-1]);
      end
      FN_MUL:  otp = a * b;
      FN_AND:  otp = a & b;
      FN_OR:   otp = a | b;
      FN_XOR:  otp = a ^ b;
      FN_SLL:  otp = a << shamt;
      FN_SRL:  otp = a >> shamt;
      default: otp = '0;
    endcase
    zero = (otp == '0);
  end

endmodule

// File: rtl/alu_rr_arb.sv
// alu_rr_arb: two-way arbiter for the shared ALU.
// Default build: round-robin, the port that did not win last time takes a
// contention. With ALU_SHARE_FIXED_PRIO_EN defined, port 0 always wins a
// contention (port 1 can starve); last_grant is still tracked.
module alu_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready
);

  logic       last_grant_q;
  logic       last_grant_d;
  logic [1:0] grant;

  // Pick the winner from current requests and the previous winner
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = last_grant_q ? 2'b01 : 2'b10;
`endif
      end
      default: grant = 2'b00;
    endcase
    req_ready    = en ? grant : 2'b00;
    last_grant_d = last_grant_q;
    if (|req_ready) last_grant_d = req_ready[1];
  end

  // Remember the last winner; reset favours port 0 on the first contention
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two requesters, one op in flight.
// Accept registers the operands, holds them for the op latency (MUL_CYCLES for
// multiply, 1 otherwise), then returns a tagged result held until consumed.
// Build option ALU_SHARE_FIXED_PRIO_EN selects fixed port-0 priority in alu_rr_arb.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF  // must be >= 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [11:0]        req_fn,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_otp,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic               busy
);

  localparam int            CW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

  state_e           state_q, state_d;
  logic             arb_en;
  logic             accept;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [5:0]       fn_q, fn_d;
  logic             id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] otp_q, otp_d;
  logic             ovf_q, ovf_d, zero_q, zero_d, rid_q, rid_d;
  logic [WIDTH-1:0] alu_otp;
  logic             alu_ovf, alu_zero;

  alu_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req_valid (req_valid),
    .req_ready (req_ready)
  );

  ALU #(.WIDTH(WIDTH)) u_alu (
    .alufn    (fn_q),
    .a        (a_q),
    .b        (b_q),
    .otp      (alu_otp),
    .overflow (alu_ovf),
    .zero     (alu_zero)
  );

  assign accept = |req_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: accept -> execute until count expires -> hold response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; no accept while reset is asserted
  always_comb begin
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
    arb_en    = (state_q == IDLE) && !rst;
  end

  // Datapath: capture the winner's op, count down, latch the ALU result
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    fn_d   = fn_q;
    id_d   = id_q;
    cnt_d  = cnt_q;
    otp_d  = otp_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    rid_d  = rid_q;
    if (accept) begin
      id_d = req_ready[1];
      if (req_ready[1]) begin
        a_d  = req_a[2*WIDTH-1:WIDTH];
        b_d  = req_b[2*WIDTH-1:WIDTH];
        fn_d = req_fn[11:6];
      end else begin
        a_d  = req_a[WIDTH-1:0];
        b_d  = req_b[WIDTH-1:0];
        fn_d = req_fn[5:0];
      end
      cnt_d = (fn_d == FN_MUL) ? MUL_LOAD : '0;
    end else if (state_q == EXEC) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        otp_d  = alu_otp;
        ovf_d  = alu_ovf;
        zero_d = alu_zero;
        rid_d  = id_q;
      end
    end
  end

  // Counter and response registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      otp_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      rid_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      otp_q  <= otp_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      rid_q  <= rid_d;
    end
  end

  // Operand registers feeding the ALU
  always_ff @(posedge clk) begin
    // NOTE: no reset needed: they are only consumed in EXEC, always entered via an accept that loads them.
    a_q  <= a_d;
    b_q  <= b_d;
    fn_q <= fn_d;
    id_q <= id_d;
  end

  assign rsp_id       = rid_q;
  assign rsp_otp      = otp_q;
  assign rsp_overflow = ovf_q;
  assign rsp_zero     = zero_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed scenarios plus randomized traffic, checked each
// cycle against a transaction/timestamp model of the shared-ALU controller.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 3;
  localparam longint MAXS = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint MINS = -(64'sd1 <<< (W - 1));

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready;
  logic [2*W-1:0] req_a, req_b;
  logic [11:0]    req_fn;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_zero, busy;
  logic [W-1:0]   rsp_otp;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_fn       (req_fn),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_otp      (rsp_otp),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .busy         (busy)
  );

  typedef struct {
    logic [5:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  op_t q0[$];
  op_t q1[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference model state
  bit           pending;
  int           rsp_at;
  int           cyc;
  bit           last;
  bit           post_rst;
  logic         exp_id;
  logic [W-1:0] exp_otp;
  logic         exp_ovf, exp_zero;

  // Stimulus knobs
  bit rand_ready = 1'b0;
  bit rand_drop  = 1'b0;
  int hold_low   = 0;
  bit want_rst   = 1'b0;

  // Responses actually handed over, in order
  logic         srv_id[$];
  logic [W-1:0] srv_otp[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void ref_alu(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic ovf);
    longint sa, sb, s;
    logic [63:0] p;
    int n;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    n   = int'(b[$clog2(W)-1:0]);
    r   = '0;
    ovf = 1'b0;
    case (fn)
      FN_ADD: begin s = sa + sb; r = W'(s); ovf = (s > MAXS) || (s < MINS); end
      FN_SUB: begin s = sa - sb; r = W'(s); ovf = (s > MAXS) || (s < MINS); end
      FN_MUL: begin p = 64'(a) * 64'(b); r = p[W-1:0]; end
      FN_AND: r = a & b;
      FN_OR:  r = a | b;
      FN_XOR: r = a ^ b;
      FN_SLL: begin p = 64'(a) * (64'd1 << n); r = p[W-1:0]; end
      FN_SRL: begin p = 64'(a) / (64'd1 << n); r = p[W-1:0]; end
      default: r = '0;
    endcase
  endfunction

  // Expected grant: lone requester wins; contention goes to the port that lost last time
  function automatic logic [1:0] arb(input logic [1:0] v);
    int win;
    if (v != 2'b11) return v;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    win = 0;
`else
    win = 1 - int'(last);
`endif
    return 2'(1 << win);
  endfunction

  function automatic op_t mk(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    op_t o;
    o.fn = fn; o.a = a; o.b = b;
    return o;
  endfunction

  task automatic drive();
    rst       = want_rst;
    want_rst  = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_fn    = '0;
    if (q0.size() > 0) begin
      req_a[W-1:0] = q0[0].a;
      req_b[W-1:0] = q0[0].b;
      req_fn[5:0]  = q0[0].fn;
      req_valid[0] = !rand_drop || ($urandom_range(0, 3) != 0);
    end
    if (q1.size() > 0) begin
      req_a[2*W-1:W] = q1[0].a;
      req_b[2*W-1:W] = q1[0].b;
      req_fn[11:6]   = q1[0].fn;
      req_valid[1]   = !rand_drop || ($urandom_range(0, 3) != 0);
    end
    if (hold_low > 0) begin
      rsp_ready = 1'b0;
      hold_low--;
    end else begin
      rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  // One clock: drive, compare mid-cycle, then advance the model across the edge
  task automatic cycle();
    logic [1:0] er;
    logic       ev, hs;
    logic       g;
    op_t        op;
    drive();
    @(negedge clk);
    er = (!rst && !pending) ? arb(req_valid) : 2'b00;
    ev = pending && (cyc >= rsp_at);
    check("req_ready", 64'(req_ready), 64'(er));
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    check("busy", 64'(busy), 64'(pending));
    if (ev) begin
      check("rsp_id", 64'(rsp_id), 64'(exp_id));
      check("rsp_otp", 64'(rsp_otp), 64'(exp_otp));
      check("rsp_overflow", 64'(rsp_overflow), 64'(exp_ovf));
      check("rsp_zero", 64'(rsp_zero), 64'(exp_zero));
    end
    if (post_rst) begin
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      check("rst_rsp_otp", 64'(rsp_otp), 64'd0);
      check("rst_rsp_overflow", 64'(rsp_overflow), 64'd0);
      check("rst_rsp_zero", 64'(rsp_zero), 64'd0);
      post_rst = 1'b0;
    end
    hs = ev && rsp_ready && !rst;
    if (hs) begin
      srv_id.push_back(rsp_id);
      srv_otp.push_back(rsp_otp);
    end
    @(posedge clk);
    if (rst) begin
      pending  = 1'b0;
      last     = 1'b1;
      post_rst = 1'b1;
    end else begin
      if (hs) pending = 1'b0;
      if (er != 2'b00) begin
        g  = er[1];
        op = g ? q1.pop_front() : q0.pop_front();
        pending = 1'b1;
        last    = g;
        exp_id  = g;
        ref_alu(op.fn, op.a, op.b, exp_otp, exp_ovf);
        exp_zero = (exp_otp == '0);
        rsp_at   = cyc + 1 + ((op.fn == FN_MUL) ? MC : 1);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pending) && n < 200) begin
      cycle();
      n++;
    end
    check(tag, 64'(q0.size() == 0 && q1.size() == 0 && !pending), 64'd1);
  endtask

  function automatic op_t rand_op();
    logic [5:0] fns[10];
    op_t o;
    fns = '{FN_ADD, FN_SUB, FN_MUL, FN_AND, FN_OR, FN_XOR, FN_SLL, FN_SRL, 6'b000011, 6'b111111};
    o.fn = fns[$urandom_range(0, 9)];
    o.a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom());
    o.b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom());
    return o;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_ord[8];

    // Reset with both ports requesting: nothing may be accepted
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_fn    = '0;
    @(posedge clk);
    @(negedge clk);
    check("req_ready_in_reset", 64'(req_ready), 64'd0);
    check("busy_in_reset", 64'(busy), 64'd0);
    check("rsp_valid_in_reset", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    pending  = 1'b0;
    last     = 1'b1;
    cyc      = 0;
    post_rst = 1'b1;

    // Port 0 ADD 1+1
    q0.push_back(mk(FN_ADD, 1, 1));
    drain("drain_add");
    check("add_otp", 64'(srv_otp[0]), 64'd2);

    // Contention straight after reset: port 0 SUB first, then port 1 XOR
    want_rst = 1'b1;
    cycle();
    srv_id.delete(); srv_otp.delete();
    q0.push_back(mk(FN_SUB, 32'h13, 32'h02));
    q1.push_back(mk(FN_XOR, 1, 1));
    drain("drain_contend");
    check("contend_first_id", 64'(srv_id[0]), 64'd0);
    check("contend_first_otp", 64'(srv_otp[0]), 64'h11);
    check("contend_second_id", 64'(srv_id[1]), 64'd1);
    check("contend_second_otp", 64'(srv_otp[1]), 64'd0);

    // Sustained contention: alternation, or port 0 first under fixed priority
    srv_id.delete(); srv_otp.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(FN_ADD, W'(i), 10));
      q1.push_back(mk(FN_OR, W'(i), 32'h100));
    end
`ifdef ALU_SHARE_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_ord = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    drain("drain_order");
    for (int i = 0; i < 8; i++) check($sformatf("order_%0d", i), 64'(srv_id[i]), 64'(exp_ord[i]));

    // Port 1 multiply
    srv_id.delete(); srv_otp.delete();
    q1.push_back(mk(FN_MUL, 32'h13, 32'h02));
    drain("drain_mul");
    check("mul_otp", 64'(srv_otp[0]), 64'h26);

    // SLL under backpressure with another request waiting
    srv_id.delete(); srv_otp.delete();
    q0.push_back(mk(FN_SLL, 1, 3));
    q1.push_back(mk(FN_ADD, 5, 6));
    hold_low = 7;
    drain("drain_sll");
    check("sll_otp", 64'(srv_otp[0]), 64'd8);
    check("sll_next_otp", 64'(srv_otp[1]), 64'd11);

    // Reset during multiply EXEC aborts it; a following SRL completes
    srv_id.delete(); srv_otp.delete();
    q0.push_back(mk(FN_MUL, 7, 9));
    cycle();
    cycle();
    want_rst = 1'b1;
    cycle();
    cycle();
    q0.push_back(mk(FN_SRL, 32'h10, 3));
    drain("drain_srl");
    check("abort_count", 64'(srv_otp.size()), 64'd1);
    check("srl_otp", 64'(srv_otp[0]), 64'd2);

    // Randomized traffic with dropping valids, random backpressure, rare resets
    rand_ready = 1'b1;
    rand_drop  = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
      if ($urandom_range(0, 149) == 0) want_rst = 1'b1;
      cycle();
    end
    rand_drop = 1'b0;
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
